// File: rtl/control_unit.sv
// rtl/control_unit.sv - microsequencer: fetch/decode/execute control with bounded memory wait
// Moore outputs from state and the latched IR byte; only JZ's pc_load looks at an input.
module control_unit #(
    parameter int MEM_WAIT_MAX = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] instr,
    input  logic       mem_ready,
    input  logic       z_flag,
    output logic       mem_read,
    output logic       ir_load,
    output logic       mbru_load,
    output logic       pc_inc,
    output logic       pc_load,
    output logic [3:0] B_bus_ctrl,
    output logic [1:0] alu_op,
    output logic       ac_load,
    output logic [5:0] c_wr_en,
    output logic       halted,
    output logic       error,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_FETCH      = 4'd1,
        S_F_LATCH    = 4'd2,
        S_DECODE     = 4'd3,
        S_EXEC       = 4'd4,
        S_OPND_RD    = 4'd5,
        S_OPND_LATCH = 4'd6,
        S_EXEC_IMM   = 4'd7,
        S_HALT       = 4'd8,
        S_ERROR      = 4'd9
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MEM_WAIT_MAX - 1);

    state_t     cur;
    state_t     nxt;
    logic [7:0] ir;
    logic [7:0] wait_cnt;
    logic       in_wait;
    logic       timeout;

    assign in_wait = (cur == S_FETCH) || (cur == S_OPND_RD);
    // The cycle that would be wait number MEM_WAIT_MAX gives up unless mem_ready arrives.
    assign timeout = (wait_cnt == WAIT_LAST);
    assign state   = cur;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur <= S_IDLE;
        end else begin
            cur <= nxt;
        end
    end

    // Counter is held at zero outside the wait states, so every entry starts from zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir       <= 8'h00;
            wait_cnt <= 8'h00;
        end else begin
            if (ir_load) begin
                ir <= instr;
            end
            if (in_wait && !mem_ready) begin
                wait_cnt <= wait_cnt + 8'd1;
            end else begin
                wait_cnt <= 8'h00;
            end
        end
    end

    always_comb begin
        nxt = cur;
        case (cur)
            S_IDLE:       if (start) nxt = S_FETCH;
            S_FETCH: begin
                if (mem_ready)    nxt = S_F_LATCH;
                else if (timeout) nxt = S_ERROR;
            end
            S_F_LATCH:    nxt = S_DECODE;
            S_DECODE: begin
                case (ir[7:4])
                    4'h1, 4'h2, 4'h3, 4'h4: nxt = S_EXEC;
                    4'h5, 4'h6, 4'h7:       nxt = S_OPND_RD;
                    4'hF:                   nxt = S_HALT;
                    default:                nxt = S_FETCH;
                endcase
            end
            S_EXEC:       nxt = S_FETCH;
            S_OPND_RD: begin
                if (mem_ready)    nxt = S_OPND_LATCH;
                else if (timeout) nxt = S_ERROR;
            end
            S_OPND_LATCH: nxt = S_EXEC_IMM;
            S_EXEC_IMM:   nxt = S_FETCH;
            S_HALT:       nxt = S_HALT;
            S_ERROR:      nxt = S_ERROR;
            default:      nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mem_read   = 1'b0;
        ir_load    = 1'b0;
        mbru_load  = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        B_bus_ctrl = 4'b0000;
        alu_op     = 2'b00;
        ac_load    = 1'b0;
        c_wr_en    = 6'b000000;
        halted     = 1'b0;
        error      = 1'b0;
        case (cur)
            S_FETCH, S_OPND_RD: mem_read = 1'b1;
            S_F_LATCH: begin
                ir_load = 1'b1;
                pc_inc  = 1'b1;
            end
            S_EXEC: begin
                case (ir[7:4])
                    4'h1: begin
                        B_bus_ctrl = ir[3:0];
                        alu_op     = 2'b00;
                        ac_load    = 1'b1;
                    end
                    4'h2: begin
                        B_bus_ctrl = ir[3:0];
                        alu_op     = 2'b01;
                        ac_load    = 1'b1;
                    end
                    4'h3: begin
                        B_bus_ctrl = ir[3:0];
                        alu_op     = 2'b10;
                        ac_load    = 1'b1;
                    end
                    4'h4: begin
                        // Register codes 4..9 (X..Y) map onto write-enable bits 0..5.
                        if (ir[3:0] >= 4'd4 && ir[3:0] <= 4'd9) begin
                            c_wr_en = 6'(6'b000001 << (ir[3:0] - 4'd4));
                        end
                    end
                    default: ;
                endcase
            end
            S_OPND_LATCH: begin
                mbru_load = 1'b1;
                pc_inc    = 1'b1;
            end
            S_EXEC_IMM: begin
                B_bus_ctrl = 4'b0011;
                case (ir[7:4])
                    4'h5:    ac_load = 1'b1;
                    4'h6:    pc_load = 1'b1;
                    4'h7:    pc_load = z_flag;
                    default: ;
                endcase
            end
            S_HALT:  halted = 1'b1;
            S_ERROR: error  = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - vector-queue bench for control_unit: directed table plus modelled random programs
module tb_control_unit;

    typedef struct {
        logic        rst;
        logic        start;
        logic [7:0]  instr;
        logic        mem_ready;
        logic        z_flag;
        logic [3:0]  exp_state;
        logic [19:0] exp_out;
    } vec_t;

    localparam int WMAX = 4;
    localparam logic [19:0] ZERO = 20'h0;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] instr;
    logic       mem_ready;
    logic       z_flag;
    logic       mem_read, ir_load, mbru_load, pc_inc, pc_load, ac_load, halted, error;
    logic [3:0] B_bus_ctrl;
    logic [1:0] alu_op;
    logic [5:0] c_wr_en;
    logic [3:0] state;
    logic [19:0] act;

    vec_t q[$];
    int checks = 0;
    int errors = 0;

    control_unit #(.MEM_WAIT_MAX(WMAX)) dut (
        .clk(clk), .rst(rst), .start(start), .instr(instr), .mem_ready(mem_ready),
        .z_flag(z_flag), .mem_read(mem_read), .ir_load(ir_load), .mbru_load(mbru_load),
        .pc_inc(pc_inc), .pc_load(pc_load), .B_bus_ctrl(B_bus_ctrl), .alu_op(alu_op),
        .ac_load(ac_load), .c_wr_en(c_wr_en), .halted(halted), .error(error), .state(state)
    );

    assign act = {mem_read, ir_load, mbru_load, pc_inc, pc_load, B_bus_ctrl, alu_op,
                  ac_load, c_wr_en, halted, error};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [19:0] mk(input logic mr, il, ml, pi, pl, input logic [3:0] b,
                                       input logic [1:0] a, input logic ac,
                                       input logic [5:0] cw, input logic h, e);
        return {mr, il, ml, pi, pl, b, a, ac, cw, h, e};
    endfunction

    task automatic add(input logic r, s, input logic [7:0] ins, input logic mrdy, z,
                       input logic [3:0] st, input logic [19:0] o);
        vec_t v;
        v.rst = r; v.start = s; v.instr = ins; v.mem_ready = mrdy; v.z_flag = z;
        v.exp_state = st; v.exp_out = o;
        q.push_back(v);
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [7:0] r8();
        return 8'($urandom_range(0, 255));
    endfunction

    task automatic reset_start();
        add(1, 1, 8'h00, 1, 0, 4'd0, ZERO);
        add(0, 0, 8'h00, 1, 0, 4'd0, ZERO);
        add(0, 1, 8'h00, 1, 0, 4'd0, ZERO);
    endtask

    task automatic fetch_ok();
        add(0, 0, 8'h00, 1, 0, 4'd1, mk(1,0,0,0,0,4'd0,2'd0,0,6'd0,0,0));
    endtask

    task automatic latch(input logic [7:0] ins);
        add(0, 0, ins, 1, 0, 4'd2, mk(0,1,0,1,0,4'd0,2'd0,0,6'd0,0,0));
        add(0, 0, 8'h00, 1, 0, 4'd3, ZERO);
    endtask

    // Reference: expands one instruction into its expected per-cycle trace from the
    // instruction-class rules, with wf/wo memory stall cycles before fetch/operand data.
    task automatic model_instr(input logic [7:0] ins, opnd, input int wf, wo, input logic z);
        int c = int'(ins[7:4]);
        int lo = int'(ins[3:0]);
        logic [5:0] cw;
        for (int i = 0; i < wf; i++)
            add(0, rb(), r8(), 0, rb(), 4'd1, mk(1,0,0,0,0,4'd0,2'd0,0,6'd0,0,0));
        add(0, rb(), r8(), 1, rb(), 4'd1, mk(1,0,0,0,0,4'd0,2'd0,0,6'd0,0,0));
        add(0, rb(), ins, rb(), rb(), 4'd2, mk(0,1,0,1,0,4'd0,2'd0,0,6'd0,0,0));
        add(0, rb(), r8(), rb(), rb(), 4'd3, ZERO);
        if (c >= 1 && c <= 3) begin
            add(0, rb(), r8(), rb(), rb(), 4'd4, mk(0,0,0,0,0,4'(lo),2'(c - 1),1,6'd0,0,0));
        end else if (c == 4) begin
            cw = (lo >= 4 && lo <= 9) ? 6'(1 << (lo - 4)) : 6'd0;
            add(0, rb(), r8(), rb(), rb(), 4'd4, mk(0,0,0,0,0,4'd0,2'd0,0,cw,0,0));
        end else if (c >= 5 && c <= 7) begin
            for (int i = 0; i < wo; i++)
                add(0, rb(), r8(), 0, rb(), 4'd5, mk(1,0,0,0,0,4'd0,2'd0,0,6'd0,0,0));
            add(0, rb(), r8(), 1, rb(), 4'd5, mk(1,0,0,0,0,4'd0,2'd0,0,6'd0,0,0));
            add(0, rb(), opnd, rb(), rb(), 4'd6, mk(0,0,1,1,0,4'd0,2'd0,0,6'd0,0,0));
            add(0, rb(), r8(), rb(), z, 4'd7,
                mk(0,0,0,0,(c == 6) || (c == 7 && z),4'd3,2'd0,(c == 5),6'd0,0,0));
        end else if (c == 15) begin
            for (int i = 0; i < 3; i++)
                add(0, rb(), r8(), rb(), rb(), 4'd8, mk(0,0,0,0,0,4'd0,2'd0,0,6'd0,1,0));
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        rst = v.rst; start = v.start; instr = v.instr; mem_ready = v.mem_ready; z_flag = v.z_flag;
        #1;
        checks++;
        if (state !== v.exp_state) begin
            errors++;
            $display("FAIL vec%0d state: got %0d want %0d", idx, state, v.exp_state);
        end
        checks++;
        if (act !== v.exp_out) begin
            errors++;
            $display("FAIL vec%0d outputs (st %0d): got %05h want %05h", idx, v.exp_state, act, v.exp_out);
        end
        checks++;
        if (pc_inc && pc_load) begin
            errors++;
            $display("FAIL vec%0d pc_inc_and_pc_load: got 1 want 0", idx);
        end
    endtask

    initial begin
        logic [7:0] ins;
        int k;
        rst = 1'b1; start = 1'b0; instr = 8'h00; mem_ready = 1'b0; z_flag = 1'b0;

        // Directed: LOAD X, STORE, JZ taken/not taken, NOPs, HALT with start ignored
        reset_start();
        fetch_ok();
        latch(8'h14);
        add(0, 0, 8'h00, 1, 0, 4'd4, mk(0,0,0,0,0,4'b0100,2'b00,1,6'd0,0,0));
        fetch_ok();
        latch(8'h47);
        add(0, 0, 8'h00, 1, 0, 4'd4, mk(0,0,0,0,0,4'b0000,2'b00,0,6'b001000,0,0));
        fetch_ok();
        latch(8'h4A);
        add(0, 0, 8'h00, 1, 0, 4'd4, ZERO);
        for (int zz = 1; zz >= 0; zz--) begin
            fetch_ok();
            latch(8'h70);
            add(0, 0, 8'h00, 1, 0, 4'd5, mk(1,0,0,0,0,4'd0,2'd0,0,6'd0,0,0));
            add(0, 0, 8'h3C, 1, 0, 4'd6, mk(0,0,1,1,0,4'd0,2'd0,0,6'd0,0,0));
            add(0, 0, 8'h00, 1, 1'(zz), 4'd7, mk(0,0,0,0,1'(zz),4'b0011,2'd0,0,6'd0,0,0));
        end
        fetch_ok();
        latch(8'h00);
        fetch_ok();
        latch(8'h9F);
        fetch_ok();
        latch(8'hF0);
        for (int i = 0; i < 3; i++)
            add(0, 1, 8'h00, 1, 0, 4'd8, mk(0,0,0,0,0,4'd0,2'd0,0,6'd0,1,0));

        // Fetch timeout: four stalled cycles then sticky ERROR
        reset_start();
        for (int i = 0; i < WMAX; i++)
            add(0, 0, 8'h00, 0, 0, 4'd1, mk(1,0,0,0,0,4'd0,2'd0,0,6'd0,0,0));
        for (int i = 0; i < 3; i++)
            add(0, 1, 8'h00, 1, 0, 4'd9, mk(0,0,0,0,0,4'd0,2'd0,0,6'd0,0,1));
        // Ready on the last allowed wait cycle wins over the timeout
        reset_start();
        model_instr(8'h14, 8'h00, WMAX - 1, 0, 0);
        model_instr(8'h56, 8'h11, 0, WMAX - 1, 0);
        // Operand timeout
        fetch_ok();
        latch(8'h60);
        for (int i = 0; i < WMAX; i++)
            add(0, 0, 8'h00, 0, 0, 4'd5, mk(1,0,0,0,0,4'd0,2'd0,0,6'd0,0,0));
        add(0, 0, 8'h00, 1, 0, 4'd9, mk(0,0,0,0,0,4'd0,2'd0,0,6'd0,0,1));
        // Reset during OPND_RD drops everything in the same cycle
        reset_start();
        fetch_ok();
        latch(8'h50);
        add(0, 0, 8'h00, 0, 0, 4'd5, mk(1,0,0,0,0,4'd0,2'd0,0,6'd0,0,0));
        add(1, 0, 8'h00, 0, 0, 4'd0, ZERO);
        add(0, 0, 8'h00, 1, 0, 4'd0, ZERO);

        // Random programs
        for (int s = 0; s < 25; s++) begin
            reset_start();
            for (int n = 0; n < 12; n++) begin
                k = int'($urandom_range(0, 15));
                if (k == 15 && n != 11) k = 1;
                ins = {4'(k), 4'($urandom_range(0, 15))};
                model_instr(ins, r8(), int'($urandom_range(0, WMAX - 1)),
                            int'($urandom_range(0, WMAX - 1)), rb());
                if (k == 15) break;
            end
        end

        for (int i = 0; i < q.size(); i++)
            apply(q[i], i);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
